// File: rtl/serializer_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : serializer_scheduler_if
// Purpose  : Bundles the requester handshakes, the training request and the
//            frame bus that feeds the D x S-to-D output serializer.
// Ports    : ch0/ch1 valid/data/ready - two parallel-word requesters
//            train_req                 - level request for training frames
//            frame_out/ser_reset/phase - serializer-facing frame bus
//            frame_src/train_active    - status of the current frame
// Modports : slave  - the scheduler (accepts requests, drives the frame bus)
//            master - the environment (requesters, serializer, monitors)
// Revision : 1.0 - initial release
// ============================================================================
interface serializer_scheduler_if #(
  parameter int D = 8,
  parameter int S = 4
);
  localparam int c_phase_w = $clog2(S);

  logic                 ch0_valid;
  logic [D*S-1:0]       ch0_data;
  logic                 ch0_ready;
  logic                 ch1_valid;
  logic [D*S-1:0]       ch1_data;
  logic                 ch1_ready;
  logic                 train_req;
  logic [D*S-1:0]       frame_out;
  logic                 ser_reset;
  logic [c_phase_w-1:0] phase;
  logic [1:0]           frame_src;
  logic                 train_active;

  modport slave (
    input  ch0_valid, ch0_data, ch1_valid, ch1_data, train_req,
    output ch0_ready, ch1_ready, frame_out, ser_reset, phase, frame_src,
           train_active
  );

  modport master (
    output ch0_valid, ch0_data, ch1_valid, ch1_data, train_req,
    input  ch0_ready, ch1_ready, frame_out, ser_reset, phase, frame_src,
           train_active
  );
endinterface
`default_nettype wire

// File: rtl/serializer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : serializer_scheduler
// Purpose  : Frame scheduler for the D x S-to-D output serializer. Arbitrates
//            two requesters round-robin, inserts idle and training frames and
//            keeps the serializer slice counter phase-aligned to the frame
//            boundary through a registered serializer reset.
// Ports    : high_speed_clock - sole clock
//            reset_n          - asynchronous active-low reset
//            bus (slave)      - requester handshakes, train_req, frame bus
// Revision : 1.0 - initial release
// ============================================================================
module serializer_scheduler #(
  parameter int             D             = 8,
  parameter int             S             = 4,
  parameter logic [D*S-1:0] IDLE_PATTERN  = (D*S)'({S{8'h00}}),
  parameter logic [D*S-1:0] TRAIN_PATTERN = (D*S)'({(S/2){8'hF0, 8'h0F}}),
  parameter int             TRAIN_MIN     = 4
) (
  input  wire logic             high_speed_clock,
  input  wire logic             reset_n,
  serializer_scheduler_if.slave bus
);

  localparam int c_phase_w = $clog2(S);
  localparam int c_cnt_w   = $clog2(TRAIN_MIN + 1);

  localparam logic [c_phase_w-1:0] c_last_phase = c_phase_w'(S - 1);
  localparam logic [c_cnt_w-1:0]   c_train_min  = c_cnt_w'(TRAIN_MIN);

  localparam logic [1:0] c_src_idle  = 2'd0;
  localparam logic [1:0] c_src_ch0   = 2'd1;
  localparam logic [1:0] c_src_ch1   = 2'd2;
  localparam logic [1:0] c_src_train = 2'd3;

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_RUN   = 2'd1,
    ST_TRAIN = 2'd2
  } state_t;

  state_t               state_q,        state_d;
  logic [c_phase_w-1:0] phase_q,        phase_d;
  logic [D*S-1:0]       frame_q,        frame_d;
  logic [1:0]           frame_src_q,    frame_src_d;
  logic                 ser_reset_q,    ser_reset_d;
  logic                 train_active_q, train_active_d;
  logic                 last_grant_q,   last_grant_d;   // 0 = ch0, 1 = ch1
  logic [c_cnt_w-1:0]   train_cnt_q,    train_cnt_d;

  logic boundary;
  logic any_valid;
  logic win_ch1;
  logic accept;
  logic ch0_ready;
  logic ch1_ready;

  // ch1 wins when it is the only requester, or on a tie when ch0 had the
  // previous grant.
  assign boundary  = (phase_q == c_last_phase);
  assign any_valid = bus.ch0_valid | bus.ch1_valid;
  assign win_ch1   = bus.ch1_valid & (~bus.ch0_valid | ~last_grant_q);

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q + c_phase_w'(1);   // S is a power of 2: wraps
    frame_d        = frame_q;
    frame_src_d    = frame_src_q;
    ser_reset_d    = ser_reset_q;
    last_grant_d   = last_grant_q;
    train_cnt_d    = train_cnt_q;
    accept         = 1'b0;
    ch0_ready      = 1'b0;
    ch1_ready      = 1'b0;

    if (boundary) begin
      case (state_q)
        ST_ALIGN: begin
          // Releasing ser_reset here lets the serializer sample it high on
          // the same edge where phase wraps, so both counters agree from 0.
          frame_d     = IDLE_PATTERN;
          frame_src_d = c_src_idle;
          ser_reset_d = 1'b0;
          state_d     = ST_RUN;
        end
        ST_RUN: begin
          if (bus.train_req) begin
            frame_d     = TRAIN_PATTERN;
            frame_src_d = c_src_train;
            train_cnt_d = c_cnt_w'(1);
            state_d     = ST_TRAIN;
          end else begin
            accept = 1'b1;
          end
        end
        ST_TRAIN: begin
          if ((train_cnt_q < c_train_min) || bus.train_req) begin
            frame_d     = TRAIN_PATTERN;
            frame_src_d = c_src_train;
            if (train_cnt_q < c_train_min) begin
              train_cnt_d = train_cnt_q + c_cnt_w'(1);
            end
          end else begin
            // Leave training and schedule normally at this same boundary so
            // no idle frame is inserted. The loaded frame is handshaken like
            // any RUN grant so the requester does not resend it.
            state_d = ST_RUN;
            accept  = 1'b1;
          end
        end
        default: begin
          state_d = ST_ALIGN;
        end
      endcase

      if (accept) begin
        if (any_valid) begin
          if (win_ch1) begin
            ch1_ready    = 1'b1;
            frame_d      = bus.ch1_data;
            frame_src_d  = c_src_ch1;
            last_grant_d = 1'b1;
          end else begin
            ch0_ready    = 1'b1;
            frame_d      = bus.ch0_data;
            frame_src_d  = c_src_ch0;
            last_grant_d = 1'b0;
          end
        end else begin
          frame_d     = IDLE_PATTERN;
          frame_src_d = c_src_idle;
        end
      end
    end

    train_active_d = (state_d == ST_TRAIN);
  end

  always_ff @(posedge high_speed_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_ALIGN;
      phase_q        <= '0;
      frame_q        <= IDLE_PATTERN;
      frame_src_q    <= c_src_idle;
      ser_reset_q    <= 1'b1;
      train_active_q <= 1'b0;
      last_grant_q   <= 1'b1;   // ch0 wins the first tie after reset
      train_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      frame_q        <= frame_d;
      frame_src_q    <= frame_src_d;
      ser_reset_q    <= ser_reset_d;
      train_active_q <= train_active_d;
      last_grant_q   <= last_grant_d;
      train_cnt_q    <= train_cnt_d;
    end
  end

  // ready is combinational, so gate it with reset_n to drop it the moment
  // reset is asserted rather than at the next edge.
  assign bus.ch0_ready    = ch0_ready & reset_n;
  assign bus.ch1_ready    = ch1_ready & reset_n;
  assign bus.frame_out    = frame_q;
  assign bus.ser_reset    = ser_reset_q;
  assign bus.phase        = phase_q;
  assign bus.frame_src    = frame_src_q;
  assign bus.train_active = train_active_q;

endmodule
`default_nettype wire

// File: tb/tb_serializer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_serializer_scheduler
// Purpose  : Directed self-checking bench for serializer_scheduler
//            (D=8, S=4, TRAIN_MIN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serializer_scheduler;

  localparam int          D     = 8;
  localparam int          S     = 4;
  localparam logic [31:0] IDLE  = 32'h0000_0000;
  localparam logic [31:0] TRAIN = 32'hF00F_F00F;

  logic high_speed_clock = 1'b0;
  logic reset_n          = 1'b0;
  int   checks = 0;
  int   errors = 0;

  serializer_scheduler_if #(.D(D), .S(S)) bus ();

  serializer_scheduler #(.D(D), .S(S), .TRAIN_MIN(4)) dut (
    .high_speed_clock(high_speed_clock),
    .reset_n         (reset_n),
    .bus             (bus)
  );

  always #5 high_speed_clock = ~high_speed_clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance (sampling at negedge+1) until phase equals p, bounded.
  task automatic goto_phase(input int p);
    int n;
    n = 0;
    while (int'(bus.phase) != p && n < 16) begin
      @(negedge high_speed_clock); #1;
      n++;
    end
    if (int'(bus.phase) != p) begin
      checks++; errors++;
      $display("FAIL goto_phase timeout: phase=%0d required %0d", bus.phase, p);
    end
  endtask

  task automatic test_reset();
    bus.ch0_valid = 1'b0; bus.ch1_valid = 1'b0; bus.train_req = 1'b0;
    bus.ch0_data  = '0;   bus.ch1_data  = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge high_speed_clock);
    #1;
    checks++; if (bus.phase !== 2'd0) begin errors++; $display("FAIL rst_phase: got %0d want 0", bus.phase); end
    checks++; if (bus.ser_reset !== 1'b1) begin errors++; $display("FAIL rst_ser_reset: got %b want 1", bus.ser_reset); end
    checks++; if (bus.frame_out !== IDLE) begin errors++; $display("FAIL rst_frame: got %h want %h", bus.frame_out, IDLE); end
    checks++; if (bus.frame_src !== 2'd0) begin errors++; $display("FAIL rst_src: got %0d want 0", bus.frame_src); end
    checks++; if (bus.train_active !== 1'b0) begin errors++; $display("FAIL rst_train_active: got %b want 0", bus.train_active); end
    checks++; if ({bus.ch0_ready, bus.ch1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", {bus.ch0_ready, bus.ch1_ready}); end
    @(negedge high_speed_clock);
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.phase !== 2'(i % 4)) begin errors++; $display("FAIL align_phase c%0d: got %0d want %0d", i, bus.phase, i % 4); end
      checks++; if (bus.ser_reset !== (i < 4)) begin errors++; $display("FAIL align_ser_reset c%0d: got %b want %b", i, bus.ser_reset, (i < 4)); end
      checks++; if (bus.frame_out !== IDLE) begin errors++; $display("FAIL align_frame c%0d: got %h want %h", i, bus.frame_out, IDLE); end
      checks++; if ({bus.ch0_ready, bus.ch1_ready} !== 2'b00) begin errors++; $display("FAIL align_ready c%0d: got %b want 00", i, {bus.ch0_ready, bus.ch1_ready}); end
      @(negedge high_speed_clock); #1;
    end
  endtask

  // Both channels valid: ch0 wins the first tie after reset, then alternate.
  task automatic test_round_robin();
    logic        exp1;
    logic [31:0] exp_data;
    bus.ch0_data = 32'hA0A1_A2A3; bus.ch1_data = 32'hB0B1_B2B3;
    bus.ch0_valid = 1'b1; bus.ch1_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      goto_phase(3);
      exp1 = (j % 2 == 1);
      checks++; if (bus.ch0_ready !== !exp1) begin errors++; $display("FAIL rr_ch0_ready #%0d: got %b want %b", j, bus.ch0_ready, !exp1); end
      checks++; if (bus.ch1_ready !== exp1) begin errors++; $display("FAIL rr_ch1_ready #%0d: got %b want %b", j, bus.ch1_ready, exp1); end
      exp_data = exp1 ? bus.ch1_data : bus.ch0_data;
      @(negedge high_speed_clock); #1;
      checks++; if (bus.frame_out !== exp_data) begin errors++; $display("FAIL rr_frame #%0d: got %h want %h", j, bus.frame_out, exp_data); end
      checks++; if (bus.frame_src !== (exp1 ? 2'd2 : 2'd1)) begin errors++; $display("FAIL rr_src #%0d: got %0d want %0d", j, bus.frame_src, exp1 ? 2 : 1); end
      checks++; if ({bus.ch0_ready, bus.ch1_ready} !== 2'b00) begin errors++; $display("FAIL rr_ready_nonboundary #%0d: got %b want 00", j, {bus.ch0_ready, bus.ch1_ready}); end
      if (exp1) bus.ch1_data = bus.ch1_data + 32'd1;
      else      bus.ch0_data = bus.ch0_data + 32'd1;
    end
    bus.ch0_valid = 1'b0; bus.ch1_valid = 1'b0;
  endtask

  // One ch0 frame: ready only in the boundary cycle, slices 11,22,33,44,
  // then an idle frame once valid drops.
  task automatic test_single();
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    goto_phase(2);
    bus.ch0_valid = 1'b1; bus.ch0_data = 32'h4433_2211;
    #1;
    checks++; if (bus.ch0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_early: got %b want 0", bus.ch0_ready); end
    @(negedge high_speed_clock); #1;
    checks++; if (bus.ch0_ready !== 1'b1) begin errors++; $display("FAIL single_ready_boundary: got %b want 1", bus.ch0_ready); end
    @(negedge high_speed_clock);
    bus.ch0_valid = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.frame_out[bus.phase*8 +: 8] !== exp_b[k]) begin errors++; $display("FAIL single_slice%0d: got %h want %h", k, bus.frame_out[bus.phase*8 +: 8], exp_b[k]); end
      checks++; if (bus.frame_src !== 2'd1) begin errors++; $display("FAIL single_src c%0d: got %0d want 1", k, bus.frame_src); end
      @(negedge high_speed_clock); #1;
    end
    checks++; if (bus.frame_out !== IDLE) begin errors++; $display("FAIL single_idle_frame: got %h want %h", bus.frame_out, IDLE); end
    checks++; if (bus.frame_src !== 2'd0) begin errors++; $display("FAIL single_idle_src: got %0d want 0", bus.frame_src); end
  endtask

  // One-boundary train_req pulse: four training frames, then the pending
  // ch1 frame with no idle gap.
  task automatic test_train_min();
    goto_phase(2);
    bus.train_req = 1'b1; bus.ch1_valid = 1'b1; bus.ch1_data = 32'hC3C2_C1C0;
    #1;
    for (int f = 0; f < 4; f++) begin
      goto_phase(3);
      checks++; if ({bus.ch0_ready, bus.ch1_ready} !== 2'b00) begin errors++; $display("FAIL tmin_ready #%0d: got %b want 00", f, {bus.ch0_ready, bus.ch1_ready}); end
      @(negedge high_speed_clock);
      bus.train_req = 1'b0;
      #1;
      checks++; if (bus.frame_out !== TRAIN) begin errors++; $display("FAIL tmin_frame #%0d: got %h want %h", f, bus.frame_out, TRAIN); end
      checks++; if (bus.frame_src !== 2'd3) begin errors++; $display("FAIL tmin_src #%0d: got %0d want 3", f, bus.frame_src); end
      checks++; if (bus.train_active !== 1'b1) begin errors++; $display("FAIL tmin_active #%0d: got %b want 1", f, bus.train_active); end
    end
    goto_phase(3);
    checks++; if (bus.ch1_ready !== 1'b1) begin errors++; $display("FAIL tmin_exit_ready: got %b want 1", bus.ch1_ready); end
    @(negedge high_speed_clock);
    bus.ch1_valid = 1'b0;
    #1;
    checks++; if (bus.frame_out !== 32'hC3C2_C1C0) begin errors++; $display("FAIL tmin_exit_frame: got %h want c3c2c1c0", bus.frame_out); end
    checks++; if (bus.frame_src !== 2'd2) begin errors++; $display("FAIL tmin_exit_src: got %0d want 2", bus.frame_src); end
    checks++; if (bus.train_active !== 1'b0) begin errors++; $display("FAIL tmin_exit_active: got %b want 0", bus.train_active); end
  endtask

  // train_req held for 7 boundaries: seven training frames, then RUN.
  task automatic test_train_ext();
    goto_phase(2);
    bus.train_req = 1'b1; bus.ch0_valid = 1'b1; bus.ch0_data = 32'h5566_7788;
    #1;
    for (int b = 0; b < 7; b++) begin
      goto_phase(3);
      checks++; if ({bus.ch0_ready, bus.ch1_ready} !== 2'b00) begin errors++; $display("FAIL text_ready #%0d: got %b want 00", b, {bus.ch0_ready, bus.ch1_ready}); end
      @(negedge high_speed_clock);
      if (b == 6) bus.train_req = 1'b0;
      #1;
      checks++; if (bus.frame_out !== TRAIN) begin errors++; $display("FAIL text_frame #%0d: got %h want %h", b, bus.frame_out, TRAIN); end
      checks++; if (bus.train_active !== 1'b1) begin errors++; $display("FAIL text_active #%0d: got %b want 1", b, bus.train_active); end
    end
    goto_phase(3);
    checks++; if (bus.ch0_ready !== 1'b1) begin errors++; $display("FAIL text_exit_ready: got %b want 1", bus.ch0_ready); end
    @(negedge high_speed_clock);
    bus.ch0_valid = 1'b0;
    #1;
    checks++; if (bus.frame_out !== 32'h5566_7788) begin errors++; $display("FAIL text_exit_frame: got %h want 55667788", bus.frame_out); end
    checks++; if (bus.frame_src !== 2'd1) begin errors++; $display("FAIL text_exit_src: got %0d want 1", bus.frame_src); end
    checks++; if (bus.train_active !== 1'b0) begin errors++; $display("FAIL text_exit_active: got %b want 0", bus.train_active); end
  endtask

  // Reset mid ch1 frame: outputs clear without a clock edge, then the
  // alignment sequence repeats with no ready issued during ALIGN.
  task automatic test_async_reset();
    bus.ch1_valid = 1'b1; bus.ch1_data = 32'h99AA_BBCC;
    #1;
    goto_phase(3);
    checks++; if (bus.ch1_ready !== 1'b1) begin errors++; $display("FAIL ar_accept_ready: got %b want 1", bus.ch1_ready); end
    @(negedge high_speed_clock);
    bus.ch1_valid = 1'b0;
    #1;
    checks++; if (bus.frame_src !== 2'd2) begin errors++; $display("FAIL ar_src_before: got %0d want 2", bus.frame_src); end
    goto_phase(2);
    reset_n = 1'b0;
    bus.ch0_valid = 1'b1; bus.ch0_data = 32'h1234_5678;
    #1;
    checks++; if (bus.frame_out !== IDLE) begin errors++; $display("FAIL ar_frame: got %h want %h", bus.frame_out, IDLE); end
    checks++; if (bus.ser_reset !== 1'b1) begin errors++; $display("FAIL ar_ser_reset: got %b want 1", bus.ser_reset); end
    checks++; if (bus.phase !== 2'd0) begin errors++; $display("FAIL ar_phase: got %0d want 0", bus.phase); end
    checks++; if (bus.frame_src !== 2'd0) begin errors++; $display("FAIL ar_src: got %0d want 0", bus.frame_src); end
    repeat (2) @(negedge high_speed_clock);
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.phase !== 2'(i % 4)) begin errors++; $display("FAIL realign_phase c%0d: got %0d want %0d", i, bus.phase, i % 4); end
      checks++; if (bus.ser_reset !== (i < 4)) begin errors++; $display("FAIL realign_ser_reset c%0d: got %b want %b", i, bus.ser_reset, (i < 4)); end
      checks++; if (bus.frame_out !== IDLE) begin errors++; $display("FAIL realign_frame c%0d: got %h want %h", i, bus.frame_out, IDLE); end
      checks++; if (bus.ch0_ready !== 1'b0) begin errors++; $display("FAIL realign_ready c%0d: got %b want 0", i, bus.ch0_ready); end
      @(negedge high_speed_clock); #1;
    end
    bus.ch0_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_train_min();
    test_train_ext();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
